// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer.
// Holds the playback FSM state enum, draw colour constants, the rest note
// code and the grid cell origin helper.
package note_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } seq_state_e;

  localparam logic [2:0] COL_REC  = 3'b100;
  localparam logic [2:0] COL_PLAY = 3'b110;
  localparam logic [2:0] COL_DONE = 3'b010;
  localparam logic [2:0] COL_REST = 3'b001;

  localparam logic [3:0] REST_CODE = 4'hF;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } cell_pos_t;

  // Origin of the grid cell for a slot; results are truncated to the draw bus widths.
  function automatic cell_pos_t cell_origin(input int unsigned addr, input int unsigned cols,
                                            input int unsigned cell_w, input int unsigned cell_h,
                                            input int unsigned margin);
    int unsigned col;
    int unsigned row;
    int unsigned x;
    int unsigned y;
    cell_pos_t   pos;
    col   = addr % cols;
    row   = addr / cols;
    x     = margin + col * (cell_w + margin);
    y     = margin + row * (cell_h + margin);
    pos.x = x[7:0];
    pos.y = y[6:0];
    return pos;
  endfunction

endpackage

// File: rtl/seq_ram.sv
// Single-port sequence RAM with registered read (1-cycle latency).
// Ports: clk_i clock, we_i write enable, addr_i slot address,
//        wdata_i write data, rdata_o registered read data.
module seq_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 6,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: records note/octave codes into a sequence RAM, plays them
// back with a fixed per-note duration (optionally looping) and issues one
// draw request per record/play/done event for the grid display.
// Ports: clk, reset (sync active-low); record inputs note_data, octave_data,
//   rec_strobe, clear; playback controls play_start, play_stop, loop_en;
//   tone outputs note_out, octave_out, note_valid; status playing, count,
//   full; draw handshake draw_req, draw_x, draw_y, draw_colour, draw_ack.
// Build option: NOTE_SEQ_REST_EN makes note code 4'hF a silent rest.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned COLS           = 4,
  parameter int unsigned CELL_W         = 36,
  parameter int unsigned CELL_H         = 12,
  parameter int unsigned MARGIN         = 4,
  parameter int unsigned TICKS_PER_NOTE = 25000000,
  parameter int unsigned AW             = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    note_data,
  input  logic [1:0]    octave_data,
  input  logic          rec_strobe,
  input  logic          play_start,
  input  logic          play_stop,
  input  logic          loop_en,
  input  logic          clear,
  output logic [3:0]    note_out,
  output logic [1:0]    octave_out,
  output logic          note_valid,
  output logic          playing,
  output logic [AW:0]   count,
  output logic          full,
  output logic          draw_req,
  output logic [7:0]    draw_x,
  output logic [6:0]    draw_y,
  output logic [2:0]    draw_colour,
  input  logic          draw_ack
);

  localparam int unsigned    TW        = $clog2(TICKS_PER_NOTE);
  localparam logic [TW-1:0]  TickLast  = TW'(TICKS_PER_NOTE - 1);
  localparam logic [AW:0]    CountFull = (AW + 1)'(DEPTH);

  seq_state_e    state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] play_addr_q, play_addr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    note_q, note_d;
  logic [1:0]    octave_q, octave_d;
  logic          valid_q, valid_d;
  logic          req_q, req_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;

  logic          full_w;
  logic          is_last;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [5:0]    ram_rdata;
  logic          draw_issue;
  logic [AW-1:0] draw_addr;
  logic [2:0]    draw_col;
  cell_pos_t     draw_pos;

  assign full_w  = (count_q == CountFull);
  assign is_last = ((AW + 1)'(play_addr_q) + 1'b1) == count_q;

  seq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (6),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i ({octave_data, note_data}),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    play_addr_d = play_addr_q;
    tick_d      = tick_q;
    note_d      = note_q;
    octave_d    = octave_q;
    valid_d     = valid_q;
    ram_we      = 1'b0;
    draw_issue  = 1'b0;
    draw_addr   = play_addr_q;
    draw_col    = COL_PLAY;

    unique case (state_q)
      StIdle: begin
        if (play_start && (count_q != '0)) begin
          play_addr_d = '0;
          state_d     = StFetch;
        end else if (play_start) begin
          // Empty sequence: the start is ignored and the other pulses still lose.
        end else if (clear) begin
          count_d = '0;
        end else if (rec_strobe && !full_w) begin
          ram_we     = 1'b1;
          count_d    = count_q + 1'b1;
          draw_issue = 1'b1;
          draw_addr  = count_q[AW-1:0];
          draw_col   = COL_REC;
        end
      end
      StFetch: begin
        if (play_stop) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else begin
          state_d    = StHold;
          tick_d     = '0;
          note_d     = ram_rdata[3:0];
          octave_d   = ram_rdata[5:4];
          valid_d    = 1'b1;
          draw_issue = 1'b1;
          draw_col   = COL_PLAY;
`ifdef NOTE_SEQ_REST_EN
          if (ram_rdata[3:0] == REST_CODE) begin
            valid_d  = 1'b0;
            draw_col = COL_REST;
          end
`endif
        end
      end
      StHold: begin
        if (play_stop) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (tick_q == TickLast) begin
          valid_d = 1'b0;
          if (!is_last) begin
            play_addr_d = play_addr_q + 1'b1;
            state_d     = StFetch;
          end else if (loop_en) begin
            play_addr_d = '0;
            state_d     = StFetch;
          end else begin
            state_d    = StIdle;
            draw_issue = 1'b1;
            draw_col   = COL_DONE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reads use the next play address so the word is already registered by
    // the FETCH->HOLD edge and the first HOLD cycle carries the note.
    ram_addr = ram_we ? count_q[AW-1:0] : play_addr_d;
  end

  always_comb begin
    draw_pos = cell_origin(int'(draw_addr), COLS, CELL_W, CELL_H, MARGIN);
    req_d    = req_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (draw_issue) begin
      // Latest draw wins, even over an ack arriving in the same cycle.
      req_d    = 1'b1;
      x_d      = draw_pos.x;
      y_d      = draw_pos.y;
      colour_d = draw_col;
    end else if (req_q && draw_ack) begin
      req_d    = 1'b0;
      x_d      = '0;
      y_d      = '0;
      colour_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      play_addr_q <= '0;
      tick_q      <= '0;
      note_q      <= '0;
      octave_q    <= '0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      play_addr_q <= play_addr_d;
      tick_q      <= tick_d;
      note_q      <= note_d;
      octave_q    <= octave_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
    end
  end

  assign note_out    = note_q;
  assign octave_out  = octave_q;
  assign note_valid  = valid_q;
  assign playing     = (state_q != StIdle);
  assign count       = count_q;
  assign full        = full_w;
  assign draw_req    = req_q;
  assign draw_x      = x_q;
  assign draw_y      = y_q;
  assign draw_colour = colour_q;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Parametrised successor to the single-bank note store.
- Records note/octave codes into a DEPTH-entry on-chip sequence RAM.
- Plays the sequence back with a fixed per-note duration, optionally looping.
- Emits the current note/octave to the frequency selector and one draw request per event to the VGA drawing path; grid cell coordinates are computed arithmetically rather than from a fixed table.

Parameters:
- DEPTH, 16, number of sequence slots (power of two, 2..64); AW = log2(DEPTH)
- COLS, 4, grid columns; row = addr / COLS, col = addr % COLS
- CELL_W, 36, cell width in pixels
- CELL_H, 12, cell height in pixels
- MARGIN, 4, gap before each cell, in pixels
- TICKS_PER_NOTE, 25000000, clock cycles each played note is held (>= 2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- note_data  in  4  note code to record
- octave_data  in  2  octave code to record
- rec_strobe  in  1  one-cycle pulse: append {octave_data, note_data}
- play_start  in  1  one-cycle pulse: start playback at slot 0
- play_stop  in  1  one-cycle pulse: abort playback
- loop_en  in  1  level: wrap to slot 0 after the last note
- clear  in  1  one-cycle pulse: empty the sequence (IDLE only)
- note_out  out  4  note code being played
- octave_out  out  2  octave code being played
- note_valid  out  1  note_out/octave_out are valid; gates the tone generator
- playing  out  1  FSM is not IDLE
- count  out  AW+1  number of stored notes
- full  out  1  count == DEPTH
- draw_req  out  1  draw request pending
- draw_x  out  8  cell x origin
- draw_y  out  7  cell y origin
- draw_colour  out  3  fill colour
- draw_ack  in  1  consumer accepted the request

Behaviour:
- Reset (reset == 0 at posedge clk): state IDLE; count, play_addr, note_out, octave_out = 0; note_valid, playing, draw_req = 0; draw_x, draw_y, draw_colour = 0. RAM contents are not cleared.
- Cell geometry: x = MARGIN + col*(CELL_W+MARGIN); y = MARGIN + row*(CELL_H+MARGIN). Results are truncated to 8/7 bits.
- RAM: single port, registered read with 1-cycle latency. A write occurs in the cycle rec_strobe is accepted.
- Colour constants: COL_REC = 3'b100, COL_PLAY = 3'b110, COL_DONE = 3'b010.
- IDLE:
  - play_start with count > 0: load play_addr = 0 and go to FETCH. With count == 0 it is ignored.
  - rec_strobe with !full: write slot count, increment count, and issue a draw at cell(count_old) in COL_REC. When full, rec_strobe is dropped with no draw.
  - clear: count = 0, no draw.
  - Priority when several pulses coincide: play_start > clear > rec_strobe. The losers are dropped.
- FETCH (1 cycle): the RAM address is presented. Go to HOLD.
- HOLD:
  - On entry, latch the RAM output into note_out/octave_out and set note_valid = 1. The first HOLD cycle sees the data.
  - On the same entry, issue a draw at cell(play_addr) in COL_PLAY.
  - Hold for TICKS_PER_NOTE cycles, counting HOLD cycles.
  - On expiry, if play_addr == count-1: with loop_en, set play_addr = 0 and go to FETCH; otherwise go to IDLE, set note_valid = 0, and issue a draw at cell(play_addr) in COL_DONE.
  - On expiry when play_addr < count-1: increment play_addr and go to FETCH.
- FETCH and HOLD: play_stop returns to IDLE next cycle and clears note_valid. rec_strobe and clear are ignored. While in FETCH, note_valid is 0 (a gap between notes).
- Draw handshake:
  - Issuing a draw sets draw_req = 1 with x/y/colour registered.
  - draw_req stays high and x/y/colour stay stable until draw_ack is sampled high; draw_req clears the following cycle.
  - A new draw issued while one is pending overwrites it (latest wins). A draw issued in the same cycle as draw_ack keeps draw_req = 1 with the new values.
- Reset mid-playback: immediate return to reset values; count = 0.

Optional Feature:
- Macro: NOTE_SEQ_REST_EN.
- Defined: note code 4'hF is a rest. In HOLD for that slot, note_valid stays 0 for the full duration and the cell draw uses COL_REST = 3'b001. Timing is otherwise unchanged.
- Undefined: 4'hF is an ordinary note code passed through with note_valid = 1.

Decomposition:
- Package note_seq_pkg: state enum (IDLE, FETCH, HOLD), COL_* constants, REST_CODE = 4'hF, and a function computing the cell origin from addr, COLS, CELL_W, CELL_H, MARGIN.
- One natural sub-module: seq_ram (parametrised DEPTH x 6 single-port RAM with registered read), replacing the vendor memory instance.

Test Plan:
- Record 3 notes {2'd1,4'd3},{2'd2,4'd0},{2'd0,4'd11}: count = 3, and three draws in 3'b100 at (4,4), (44,4), (84,4).
- Record 17 notes with DEPTH = 16: count = 16, full = 1; the 17th produces no draw and count stays 16.
- TICKS_PER_NOTE = 4, 3 notes, loop_en = 0, play_start:
  - note_valid high for 4 cycles per note, with a 1-cycle gap in FETCH.
  - note_out sequence is 3, 0, 11.
  - After the last note, a COL_DONE draw at (84,4) and playing = 0.
- Same setup with loop_en = 1, play_stop asserted mid-way through the second pass: addr wraps 2->0, then IDLE next cycle after the stop, with note_valid = 0.
- Slot 5 with COLS = 4: draw at (44,20). Hold draw_ack low for 10 cycles: draw_req and coordinates stay stable; they clear one cycle after the ack.
- Same-cycle play_start + rec_strobe in IDLE: playback starts, count unchanged. With NOTE_SEQ_REST_EN defined, a stored 4'hF gives note_valid = 0 for that slot and a draw in colour 3'b001.
